// File: rtl/pcie_axi_chan_slice.sv
// pcie_axi_chan_slice: a bank of independent valid/ready register slices.
// MODE 0 passes every channel through combinationally. MODE 1 gives each
// channel a 2-entry skid buffer, so every output is driven from a flop.
module pcie_axi_chan_slice #(
    parameter int unsigned NUM_CH     = 5,
    parameter int unsigned DATA_WIDTH = 320,
    parameter int unsigned MODE       = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              s_valid,
    output logic [NUM_CH-1:0]              s_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   s_data,
    output logic [NUM_CH-1:0]              m_valid,
    input  logic [NUM_CH-1:0]              m_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]   m_data,
    output logic [2*NUM_CH-1:0]            occupancy
);

    if (MODE == 0) begin : g_bypass

        // Pure wiring: no state, rst and clk play no part.
        assign m_valid   = s_valid;
        assign m_data    = s_data;
        assign s_ready   = m_ready;
        assign occupancy = '0;

    end else begin : g_skid

        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [DATA_WIDTH-1:0] r_head;
            logic [DATA_WIDTH-1:0] r_skid;
            logic [1:0]            r_count;
            logic [DATA_WIDTH-1:0] w_s_data;
            logic                  w_push;
            logic                  w_pop;

            assign w_s_data = s_data[i*DATA_WIDTH +: DATA_WIDTH];

            // Ready is withheld when full and throughout reset, so nothing
            // presented during reset is ever accepted.
            assign s_ready[i] = (r_count != 2'd2) && !rst;
            assign m_valid[i] = (r_count != 2'd0);
            assign m_data[i*DATA_WIDTH +: DATA_WIDTH] = r_head;
            assign occupancy[2*i +: 2] = r_count;

            assign w_push = s_valid[i] && s_ready[i];
            assign w_pop  = m_valid[i] && m_ready[i];

            // Head/skid/count update: head is always the oldest beat,
            // skid only ever holds the second one.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_count <= 2'd0;
                    r_head  <= '0;
                    r_skid  <= '0;
                end else begin
                    case (r_count)
                        2'd0: begin
                            if (w_push) begin
                                r_head  <= w_s_data;
                                r_count <= 2'd1;
                            end
                        end
                        2'd1: begin
                            if (w_push && w_pop) begin
                                r_head <= w_s_data;
                            end else if (w_push) begin
                                r_skid  <= w_s_data;
                                r_count <= 2'd2;
                            end else if (w_pop) begin
                                r_count <= 2'd0;
                            end
                        end
                        2'd2: begin
                            if (w_pop) begin
                                r_head  <= r_skid;
                                r_count <= 2'd1;
                            end
                        end
                        default: r_count <= 2'd0;
                    endcase
                end
            end
        end

    end

endmodule

// File: tb/tb_pcie_axi_chan_slice.sv
// Directed bench for pcie_axi_chan_slice: MODE 1 instance with default
// parameters plus a MODE 0 instance for the bypass build.
module tb_pcie_axi_chan_slice;

    localparam int DW = 320;
    localparam int NC = 5;

    logic              clk;
    logic              rst;
    logic [NC-1:0]     s_valid;
    logic [NC-1:0]     s_ready;
    logic [NC*DW-1:0]  s_data;
    logic [NC-1:0]     m_valid;
    logic [NC-1:0]     m_ready;
    logic [NC*DW-1:0]  m_data;
    logic [2*NC-1:0]   occupancy;

    logic [NC-1:0]     z_s_valid;
    logic [NC-1:0]     z_s_ready;
    logic [NC*DW-1:0]  z_s_data;
    logic [NC-1:0]     z_m_valid;
    logic [NC-1:0]     z_m_ready;
    logic [NC*DW-1:0]  z_m_data;
    logic [2*NC-1:0]   z_occupancy;

    int checks = 0;
    int errors = 0;

    pcie_axi_chan_slice #(.NUM_CH(NC), .DATA_WIDTH(DW), .MODE(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .occupancy (occupancy)
    );

    pcie_axi_chan_slice #(.NUM_CH(NC), .DATA_WIDTH(DW), .MODE(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (z_s_valid),
        .s_ready   (z_s_ready),
        .s_data    (z_s_data),
        .m_valid   (z_m_valid),
        .m_ready   (z_m_ready),
        .m_data    (z_m_data),
        .occupancy (z_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [DW-1:0] d);
        s_valid[ch] = v;
        s_data[ch*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] mch(input int ch);
        return m_data[ch*DW +: DW];
    endfunction

    function automatic logic [1:0] occ(input int ch);
        return occupancy[2*ch +: 2];
    endfunction

    initial begin
        rst       = 1'b1;
        s_valid   = '0;
        s_data    = '0;
        m_ready   = '0;
        z_s_valid = '0;
        z_s_data  = '0;
        z_m_ready = '0;

        // Reset state
        tick();
        tick();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_m_data0", mch(0), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", s_ready, 5'h1f);
        tick();
        chk("post_rst_m_valid", m_valid, 0);
        chk("post_rst_occ", occupancy, 0);

        // Single beat on ch0
        set_ch(0, 1'b1, 'hA5);
        m_ready[0] = 1'b1;
        tick();
        chk("single_m_valid", m_valid[0], 1);
        chk("single_m_data", mch(0), 'hA5);
        chk("single_occ1", occ(0), 1);
        set_ch(0, 1'b0, '0);
        tick();
        chk("single_drain_valid", m_valid[0], 0);
        chk("single_occ0", occ(0), 0);

        // Backpressure on ch1
        m_ready[1] = 1'b0;
        set_ch(1, 1'b1, 'h11);
        tick();
        chk("bp_occ1", occ(1), 1);
        chk("bp_head11", mch(1), 'h11);
        set_ch(1, 1'b1, 'h22);
        tick();
        chk("bp_occ2", occ(1), 2);
        chk("bp_s_ready0", s_ready[1], 0);
        set_ch(1, 1'b1, 'h33);
        tick();
        chk("bp_hold_occ", occ(1), 2);
        chk("bp_hold_data", mch(1), 'h11);
        chk("bp_hold_valid", m_valid[1], 1);
        m_ready[1] = 1'b1;
        tick();
        chk("bp_out22", mch(1), 'h22);
        chk("bp_out22_occ", occ(1), 1);
        tick();
        chk("bp_out33", mch(1), 'h33);
        chk("bp_out33_occ", occ(1), 1);
        set_ch(1, 1'b0, '0);
        tick();
        chk("bp_empty", m_valid[1], 0);

        // Streaming 16 beats on ch2
        m_ready[2] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            set_ch(2, 1'b1, DW'(32'h100 + k));
            chk("st_s_ready", s_ready[2], 1);
            tick();
            chk("st_m_valid", m_valid[2], 1);
            chk("st_m_data", mch(2), DW'(32'h100 + k));
            chk("st_occ", occ(2), 1);
        end
        set_ch(2, 1'b0, '0);
        tick();
        chk("st_end_valid", m_valid[2], 0);

        // ch3 stalled while ch4 streams
        m_ready[3] = 1'b0;
        m_ready[4] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_ch(3, 1'b1, DW'(32'h300 + ((k < 2) ? k : 2)));
            set_ch(4, 1'b1, DW'(32'h400 + k));
            tick();
            chk("iso_ch4_data", mch(4), DW'(32'h400 + k));
            chk("iso_ch4_occ", occ(4), 1);
            chk("iso_ch3_data", mch(3), 'h300);
            if (k >= 1) chk("iso_ch3_occ", occ(3), 2);
        end
        set_ch(3, 1'b0, '0);
        set_ch(4, 1'b0, '0);
        m_ready[3] = 1'b1;
        tick();
        chk("iso_ch3_drain301", mch(3), 'h301);
        chk("iso_ch4_empty", m_valid[4], 0);
        tick();
        chk("iso_ch3_empty", m_valid[3], 0);

        // Reset with ch0 full
        m_ready[0] = 1'b0;
        set_ch(0, 1'b1, 'hB1);
        tick();
        set_ch(0, 1'b1, 'hB2);
        tick();
        chk("mr_occ2", occ(0), 2);
        rst = 1'b1;
        set_ch(0, 1'b1, 'hB3);
        #1;
        chk("mr_s_ready_in_rst", s_ready, 0);
        tick();
        chk("mr_m_valid", m_valid, 0);
        chk("mr_occ", occupancy, 0);
        chk("mr_s_ready", s_ready, 0);
        rst = 1'b0;
        set_ch(0, 1'b0, '0);
        m_ready[0] = 1'b1;
        #1;
        chk("mr_s_ready_after", s_ready, 5'h1f);
        tick();
        chk("mr_no_stale", m_valid, 0);
        chk("mr_occ_after", occupancy, 0);

        // MODE 0 bypass with random traffic, rst toggled to show it is ignored
        for (int k = 0; k < 8; k++) begin
            rst = k[0];
            z_s_valid = NC'($urandom);
            z_m_ready = NC'($urandom);
            for (int w = 0; w < (NC * DW) / 32; w++) z_s_data[w*32 +: 32] = $urandom;
            #1;
            chk("m0_m_valid", z_m_valid, z_s_valid);
            chk("m0_s_ready", z_s_ready, z_m_ready);
            chk("m0_occ", z_occupancy, 0);
            for (int ch = 0; ch < NC; ch++) begin
                chk("m0_data", z_m_data[ch*DW +: DW], z_s_data[ch*DW +: DW]);
            end
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_axi_chan_slice.md
PCIE_AXI_CHAN_SLICE -- requirements
Module: pcie_axi_chan_slice

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 5, giving the number of independent valid/ready channels (AW, W, B, AR, R order by convention).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 320, giving the payload width per channel.
REQ-003 The module SHALL have parameter MODE, default 1, where 0 = combinational bypass and 1 = registered 2-entry skid buffer per channel.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port s_valid, input, NUM_CH bits: per-channel upstream valid.
REQ-007 The module SHALL have port s_ready, output, NUM_CH bits: per-channel upstream ready.
REQ-008 The module SHALL have port s_data, input, NUM_CH*DATA_WIDTH bits: upstream payloads, where channel i is at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The module SHALL have port m_valid, output, NUM_CH bits: per-channel downstream valid.
REQ-010 The module SHALL have port m_ready, input, NUM_CH bits: per-channel downstream ready.
REQ-011 The module SHALL have port m_data, output, NUM_CH*DATA_WIDTH bits: downstream payloads, packed the same way as s_data.
REQ-012 The module SHALL have port occupancy, output, 2*NUM_CH bits: per-channel entry count 0..2, where channel i is at [2*i +: 2].

Function
REQ-013 Channels SHALL be fully independent: no stall, data or state crosses between channels.
REQ-014 A transfer SHALL occur on a side in any cycle where valid and ready are both 1 on that side.
REQ-015 MODE 0 SHALL connect m_valid=s_valid, m_data=s_data and s_ready=m_ready combinationally, with occupancy held at 0 and no state.
REQ-016 In MODE 1, each channel SHALL hold a head register, a skid register and a 2-bit count in {0,1,2}.
REQ-017 MODE 1 outputs SHALL be driven from registers only: m_valid = (count!=0); m_data = head; s_ready = (count!=2) and not rst.
REQ-018 MODE 1 latency SHALL be 1 cycle from upstream acceptance to m_valid, when the channel was empty.
REQ-019 MODE 1 sustained throughput SHALL be 1 beat per cycle whenever m_ready is held at 1.
REQ-020 Count 0, push only: head <- s_data; count -> 1.
REQ-021 Count 1, push only: skid <- s_data; count -> 2.
REQ-022 Count 1, pop only: count -> 0.
REQ-023 Count 1, push and pop in the same cycle: head <- s_data; count stays 1.
REQ-024 Count 2, pop: head <- skid; count -> 1. No push can occur at count 2 because s_ready=0.
REQ-025 Count 0 SHALL NOT pop, because m_valid=0.
REQ-026 Ordering SHALL be strict FIFO per channel: no beat is dropped, duplicated or reordered.
REQ-027 m_data and m_valid SHALL remain stable while m_valid=1 and m_ready=0 (AXI stability rule).
REQ-028 occupancy SHALL equal count, updated in the same cycle as count.

Reset
REQ-029 While rst=1 in MODE 1, every channel SHALL set count=0, head=0 and skid=0, and force s_ready=0.
REQ-030 On the first cycle after rst deasserts, the outputs SHALL be m_valid=0, occupancy=0 and s_ready=all 1s.
REQ-031 A reset asserted mid-operation SHALL discard all buffered beats, with nothing emitted after reset.
REQ-032 Upstream valid presented during reset SHALL be ignored, because s_ready=0.
REQ-033 MODE 0 SHALL be unaffected by rst.

Verification
REQ-034 Single beat, MODE 1, ch0: s_data=0xA5, m_ready=1 -> m_valid rises the next cycle with m_data=0xA5; occupancy returns to 0 the cycle after.
REQ-035 Backpressure, ch1: m_ready=0; push 0x11, 0x22 -> occupancy=2 and s_ready=0; a third beat 0x33 is held; release m_ready -> output 0x11, 0x22, 0x33 in order, with no loss.
REQ-036 Streaming, ch2: 16 beats with m_ready=1 throughout -> 16 outputs on consecutive cycles after 1 cycle of latency, and occupancy stays at 1.
REQ-037 Channel isolation: stall ch3 (m_ready[3]=0) while streaming ch4 -> ch4 throughput is unaffected; ch3 holds 2 beats with its data stable.
REQ-038 Reset mid-flight: fill ch0 to count 2, assert rst for 1 cycle -> m_valid=0, occupancy=0 and s_ready=0 during reset, and all-1s s_ready afterwards; stale beats never appear.
REQ-039 MODE 0 build: random valid/ready on all channels -> m_* equals s_* in the same cycle, and occupancy stays 0.
